decode_pipe_stage: RTL and testbench

Registered RV32I instruction-decode stage with a valid/ready handshake on both sides and a 1- or 2-entry elastic buffer. It sits between the fetch stage and the execute stage of the pipelined core. It decodes the full 32-bit instruction, including rs1/rs2/rd fields. It checks funct7 legality and all-bit load/store alignment, and keeps a saturating count of illegal instructions.

---
 rtl/decode_pipe_stage.sv | 211 +++++++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_stage.sv
// RV32I decode stage between fetch and execute, with a 1- or 2-entry elastic output buffer.
// Optional CSR decode (csr_op_out / csr_wr_en_out ports) is enabled by defining CSR_DECODE_EN.
module decode_pipe_stage #(
  parameter int BUF_DEPTH     = 2,
  parameter int STRICT_FUNCT7 = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic [31:0]      instr_in,
  input  logic [1:0]       addr_lsb_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [4:0]       rs1_out,
  output logic [4:0]       rs2_out,
  output logic [4:0]       rd_out,
  output logic [3:0]       alu_opcode_out,
  output logic [2:0]       wb_mux_sel_out,
  output logic [2:0]       imm_type_out,
  output logic             alu_src_out,
  output logic             iadder_src_out,
  output logic             rf_wr_en_out,
  output logic             mem_wr_req_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic             illegal_instr_out,
  output logic             misaligned_load_out,
  output logic             misaligned_store_out,
`ifdef CSR_DECODE_EN
  output logic [2:0]       csr_op_out,
  output logic             csr_wr_en_out,
`endif
  output logic [CNT_W-1:0] illegal_cnt_out
);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_opcode;
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic       alu_src;
    logic       iadder_src;
    logic       rf_wr_en;
    logic       mem_wr_req;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       illegal;
    logic       misaligned_load;
    logic       misaligned_store;
`ifdef CSR_DECODE_EN
    logic [2:0] csr_op;
    logic       csr_wr_en;
`endif
  } bundle_t;

  localparam logic USE_SKID = 1'(BUF_DEPTH >= 2);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] grp;
  logic is_branch, is_jal, is_jalr, is_auipc, is_lui, is_op, is_op_imm;
  logic is_load, is_store, is_system, is_misc_mem, any_group;
  logic shift_imm, op_f7_bad, sh_f7_bad, misaligned, illegal, is_csr;
  bundle_t dec;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign grp    = opcode[6:2];

  assign is_branch   = grp == 5'b11000;
  assign is_jal      = grp == 5'b11011;
  assign is_jalr     = grp == 5'b11001;
  assign is_auipc    = grp == 5'b00101;
  assign is_lui      = grp == 5'b01101;
  assign is_op       = grp == 5'b01100;
  assign is_op_imm   = grp == 5'b00100;
  assign is_load     = grp == 5'b00000;
  assign is_store    = grp == 5'b01000;
  assign is_system   = grp == 5'b11100;
  assign is_misc_mem = grp == 5'b00011;
  assign any_group   = is_branch | is_jal | is_jalr | is_auipc | is_lui | is_op | is_op_imm |
                       is_load | is_store | is_system | is_misc_mem;

  // Only SUB/SRA (OP) and SRAI (shift-imm) may carry the alternate funct7 encoding.
  assign shift_imm = is_op_imm & ((funct3 == 3'b001) | (funct3 == 3'b101));
  assign op_f7_bad = is_op & ~((funct7 == 7'b0000000) |
                     ((funct7 == 7'b0100000) & ((funct3 == 3'b000) | (funct3 == 3'b101))));
  assign sh_f7_bad = shift_imm & ~((funct7 == 7'b0000000) |
                     ((funct7 == 7'b0100000) & (funct3 == 3'b101)));

  assign misaligned = ((funct3[1:0] == 2'b01) & addr_lsb_in[0]) |
                      ((funct3[1:0] == 2'b10) & (addr_lsb_in != 2'b00));

`ifdef CSR_DECODE_EN
  assign is_csr = is_system & (funct3 != 3'b000);
`else
  assign is_csr = 1'b0;
`endif

  assign illegal = ~any_group | (opcode[1:0] != 2'b11) |
                   (is_load & (funct3[1:0] == 2'b11)) | (is_store & funct3[2]) |
                   ((STRICT_FUNCT7 != 0) & (op_f7_bad | sh_f7_bad))
`ifdef CSR_DECODE_EN
                   | (is_system & (funct3 == 3'b100))
`endif
                   ;

  always_comb begin
    dec                  = '0;
    dec.rs1              = instr_in[19:15];
    dec.rs2              = instr_in[24:20];
    dec.rd               = instr_in[11:7];
    dec.alu_opcode       = {instr_in[30] & (is_op | shift_imm), funct3};
    dec.alu_src          = opcode[5];
    dec.iadder_src       = is_load | is_store | is_jalr;
    dec.rf_wr_en         = (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm |
                            is_load | is_csr) & ~illegal;
    dec.mem_wr_req       = is_store & ~misaligned & ~illegal;
    dec.load_size        = funct3[1:0];
    dec.load_unsigned    = funct3[2];
    dec.illegal          = illegal;
    dec.misaligned_load  = is_load & misaligned;
    dec.misaligned_store = is_store & misaligned;
    if (is_load)                dec.wb_mux_sel = 3'b001;
    else if (is_lui)            dec.wb_mux_sel = 3'b010;
    else if (is_auipc)          dec.wb_mux_sel = 3'b011;
    else if (is_jal | is_jalr)  dec.wb_mux_sel = 3'b101;
    else if (is_csr)            dec.wb_mux_sel = 3'b100;
    if (is_op_imm | is_load | is_jalr) dec.imm_type = 3'b001;
    else if (is_store)                 dec.imm_type = 3'b010;
    else if (is_branch)                dec.imm_type = 3'b011;
    else if (is_lui | is_auipc)        dec.imm_type = 3'b100;
    else if (is_jal)                   dec.imm_type = 3'b101;
    else if (is_csr)                   dec.imm_type = 3'b110;
`ifdef CSR_DECODE_EN
    dec.csr_op    = funct3;
    dec.csr_wr_en = is_csr & ~illegal;
`endif
  end

  bundle_t          out_q, skid_q;
  logic             out_valid_q, skid_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_fire, out_fire;

  assign ready_out = USE_SKID ? ~skid_valid_q : (~out_valid_q | ready_in);
  assign in_fire   = valid_in & ready_out;
  assign out_fire  = out_valid_q & ready_in;

  // Output register refills from the skid entry first; a stalled output parks new input in the skid.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush_in) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_fire | ~out_valid_q) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire & USE_SKID) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in)
      cnt_q <= '0;
    else if (in_fire & ~flush_in & dec.illegal & (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign valid_out            = out_valid_q;
  assign rs1_out              = out_q.rs1;
  assign rs2_out              = out_q.rs2;
  assign rd_out               = out_q.rd;
  assign alu_opcode_out       = out_q.alu_opcode;
  assign wb_mux_sel_out       = out_q.wb_mux_sel;
  assign imm_type_out         = out_q.imm_type;
  assign alu_src_out          = out_q.alu_src;
  assign iadder_src_out       = out_q.iadder_src;
  assign rf_wr_en_out         = out_q.rf_wr_en;
  assign mem_wr_req_out       = out_q.mem_wr_req;
  assign load_size_out        = out_q.load_size;
  assign load_unsigned_out    = out_q.load_unsigned;
  assign illegal_instr_out    = out_q.illegal;
  assign misaligned_load_out  = out_q.misaligned_load;
  assign misaligned_store_out = out_q.misaligned_store;
`ifdef CSR_DECODE_EN
  assign csr_op_out           = out_q.csr_op;
  assign csr_wr_en_out        = out_q.csr_wr_en;
`endif
  assign illegal_cnt_out      = cnt_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage (default build: BUF_DEPTH=2, STRICT_FUNCT7=1, CNT_W=8).
module tb_decode_pipe_stage;

  logic        clk_in = 1'b0;
  logic        reset_in, flush_in, valid_in, ready_in;
  logic [31:0] instr_in;
  logic [1:0]  addr_lsb_in;
  logic        ready_out, valid_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_opcode_out;
  logic [2:0]  wb_mux_sel_out, imm_type_out;
  logic        alu_src_out, iadder_src_out, rf_wr_en_out, mem_wr_req_out;
  logic [1:0]  load_size_out;
  logic        load_unsigned_out, illegal_instr_out, misaligned_load_out, misaligned_store_out;
  logic [7:0]  illegal_cnt_out;

  decode_pipe_stage dut (
    .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in), .instr_in(instr_in),
    .addr_lsb_in(addr_lsb_in), .valid_in(valid_in), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rd_out(rd_out), .alu_opcode_out(alu_opcode_out), .wb_mux_sel_out(wb_mux_sel_out),
    .imm_type_out(imm_type_out), .alu_src_out(alu_src_out), .iadder_src_out(iadder_src_out),
    .rf_wr_en_out(rf_wr_en_out), .mem_wr_req_out(mem_wr_req_out),
    .load_size_out(load_size_out), .load_unsigned_out(load_unsigned_out),
    .illegal_instr_out(illegal_instr_out), .misaligned_load_out(misaligned_load_out),
    .misaligned_store_out(misaligned_store_out), .illegal_cnt_out(illegal_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] aop;
    logic [2:0] wb;
    logic [2:0] imm;
    logic [3:0] ctl;
    logic [1:0] ls;
    logic       uns;
    logic       illegal;
    logic       mis_load;
    logic       mis_store;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  addr;
    exp_t        exp;
  } vec_t;

  vec_t       vecs[$];
  exp_t       exp_q[$];
  exp_t       cur_exp;
  int         total = 0;
  int         bad = 0;
  int         pops = 0;
  logic [7:0] model_cnt = 8'd0;
  logic       last_in_fire;
  logic       rand_ready;

  function automatic exp_t act_bundle();
    return {rs1_out, rs2_out, rd_out, alu_opcode_out, wb_mux_sel_out, imm_type_out,
            alu_src_out, iadder_src_out, rf_wr_en_out, mem_wr_req_out, load_size_out,
            load_unsigned_out, illegal_instr_out, misaligned_load_out, misaligned_store_out};
  endfunction

  task automatic add_vec(input logic [31:0] instr, input logic [1:0] addr,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] aop, input logic [2:0] wb, input logic [2:0] imm,
                         input logic [3:0] ctl, input logic [1:0] ls, input logic uns,
                         input logic [2:0] exc);
    vec_t v;
    v.instr = instr;
    v.addr  = addr;
    v.exp   = {rs1, rs2, rd, aop, wb, imm, ctl, ls, uns, exc};
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  // One clock: score any output transfer, record any input transfer, then advance past the edge.
  task automatic tick();
    logic in_fire, out_fire;
    #1;
    in_fire  = valid_in && ready_out && !reset_in;
    out_fire = valid_out && ready_in && !reset_in;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got=%0h want=none", act_bundle());
      end else begin
        check_output($sformatf("bundle%0d", pops), 64'(act_bundle()), 64'(exp_q.pop_front()));
        pops++;
      end
    end
    if (reset_in) begin
      exp_q.delete();
      model_cnt = 8'd0;
    end else if (flush_in) begin
      exp_q.delete();
    end else if (in_fire) begin
      exp_q.push_back(cur_exp);
      if (cur_exp.illegal && model_cnt != 8'hFF) model_cnt++;
    end
    last_in_fire = in_fire;
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_stimulus(input int i);
    instr_in    = vecs[i].instr;
    addr_lsb_in = vecs[i].addr;
    cur_exp     = vecs[i].exp;
    valid_in    = 1'b1;
  endtask

  task automatic send(input int i);
    int guard;
    apply_stimulus(i);
    guard = 0;
    do begin
      ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end while (!last_in_fire && guard < 50);
    if (!last_in_fire) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: got=stalled want=accepted vec=%0d", i);
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int guard;
    valid_in = 1'b0;
    ready_in = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    check_output("drain_empty", 64'(exp_q.size()), 64'd0);
    check_output("drain_valid", 64'(valid_out), 64'd0);
  endtask

  initial begin
    //       instr         addr   rs1 rs2 rd  aop      wb      imm     ctl      ls     u     exc
    add_vec(32'h00500093, 2'b00, 0,  5,  1,  4'b0000, 3'b000, 3'b001, 4'b0010, 2'b00, 1'b0, 3'b000); // ADDI
    add_vec(32'h002081B3, 2'b00, 1,  2,  3,  4'b0000, 3'b000, 3'b000, 4'b1010, 2'b00, 1'b0, 3'b000); // ADD
    add_vec(32'h407302B3, 2'b00, 6,  7,  5,  4'b1000, 3'b000, 3'b000, 4'b1010, 2'b00, 1'b0, 3'b000); // SUB
    add_vec(32'h40325213, 2'b00, 4,  3,  4,  4'b1101, 3'b000, 3'b001, 4'b0010, 2'b01, 1'b1, 3'b000); // SRAI
    add_vec(32'h00C12403, 2'b10, 2,  12, 8,  4'b0010, 3'b001, 3'b001, 4'b0110, 2'b10, 1'b0, 3'b010); // LW mis
    add_vec(32'h00952223, 2'b01, 10, 9,  4,  4'b0010, 3'b000, 3'b010, 4'b1100, 2'b10, 1'b0, 3'b001); // SW mis
    add_vec(32'h00950223, 2'b11, 10, 9,  4,  4'b0000, 3'b000, 3'b010, 4'b1101, 2'b00, 1'b0, 3'b000); // SB
    add_vec(32'h023100B3, 2'b00, 2,  3,  1,  4'b0000, 3'b000, 3'b000, 4'b1000, 2'b00, 1'b0, 3'b100); // OP f7=1
    add_vec(32'h123453B7, 2'b00, 8,  3,  7,  4'b0101, 3'b010, 3'b100, 4'b1010, 2'b01, 1'b1, 3'b000); // LUI
    add_vec(32'h000000EF, 2'b00, 0,  0,  1,  4'b0000, 3'b101, 3'b101, 4'b1010, 2'b00, 1'b0, 3'b000); // JAL
    add_vec(32'h00008067, 2'b00, 1,  0,  0,  4'b0000, 3'b101, 3'b001, 4'b1110, 2'b00, 1'b0, 3'b000); // JALR
    add_vec(32'h300312F3, 2'b00, 6,  0,  5,  4'b0001, 3'b000, 3'b000, 4'b1000, 2'b01, 1'b0, 3'b000); // CSRRW
    add_vec(32'h00500092, 2'b00, 0,  5,  1,  4'b0000, 3'b000, 3'b001, 4'b0000, 2'b00, 1'b0, 3'b100); // bad [1:0]
    add_vec(32'h00013083, 2'b00, 2,  0,  1,  4'b0011, 3'b001, 3'b001, 4'b0100, 2'b11, 1'b0, 3'b100); // LD
    add_vec(32'h40109093, 2'b00, 1,  1,  1,  4'b1001, 3'b000, 3'b001, 4'b0000, 2'b01, 1'b0, 3'b100); // SLLI alt
    add_vec(32'h00019103, 2'b01, 3,  0,  2,  4'b0001, 3'b001, 3'b001, 4'b0110, 2'b01, 1'b0, 3'b010); // LH mis
    add_vec(32'h00208063, 2'b00, 1,  2,  0,  4'b0000, 3'b000, 3'b011, 4'b1000, 2'b00, 1'b0, 3'b000); // BEQ
    add_vec(32'h00001197, 2'b00, 0,  0,  3,  4'b0001, 3'b011, 3'b100, 4'b0010, 2'b01, 1'b0, 3'b000); // AUIPC
    add_vec(32'h0000000F, 2'b00, 0,  0,  0,  4'b0000, 3'b000, 3'b000, 4'b0000, 2'b00, 1'b0, 3'b000); // FENCE

    reset_in    = 1'b1;
    flush_in    = 1'b0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    instr_in    = 32'h0;
    addr_lsb_in = 2'b00;
    rand_ready  = 1'b0;
    cur_exp     = '0;
    repeat (3) tick();
    reset_in = 1'b0;
    check_output("reset_valid", 64'(valid_out), 64'd0);
    check_output("reset_bundle", 64'(act_bundle()), 64'd0);
    check_output("reset_cnt", 64'(illegal_cnt_out), 64'd0);
    check_output("reset_ready", 64'(ready_out), 64'd1);

    $display("[TB] table pass, downstream always ready");
    for (int i = 0; i < vecs.size(); i++) send(i);
    drain();
    check_output("cnt_pass1", 64'(illegal_cnt_out), 64'(model_cnt));

    $display("[TB] table pass, random backpressure and gaps");
    rand_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ready_in = 1'($urandom_range(0, 1));
        tick();
      end
      send(i);
    end
    rand_ready = 1'b0;
    drain();
    check_output("cnt_pass2", 64'(illegal_cnt_out), 64'(model_cnt));

    $display("[TB] skid fill and ordered release");
    ready_in = 1'b0;
    apply_stimulus(1);
    tick();
    apply_stimulus(2);
    tick();
    valid_in = 1'b0;
    check_output("skid_ready_low", 64'(ready_out), 64'd0);
    tick();
    check_output("skid_hold_valid", 64'(valid_out), 64'd1);
    check_output("skid_hold_bundle", 64'(act_bundle()), 64'(vecs[1].exp));
    ready_in = 1'b1;
    tick();
    tick();
    check_output("skid_released", 64'(exp_q.size()), 64'd0);
    check_output("skid_empty_valid", 64'(valid_out), 64'd0);

    $display("[TB] flush with stalled output");
    ready_in = 1'b0;
    apply_stimulus(1);
    tick();
    apply_stimulus(7);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check_output("flush_valid", 64'(valid_out), 64'd0);
    check_output("flush_ready", 64'(ready_out), 64'd1);
    check_output("flush_cnt", 64'(illegal_cnt_out), 64'(model_cnt));
    apply_stimulus(1);
    tick();
    apply_stimulus(2);
    tick();
    valid_in = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    check_output("flush_skid_valid", 64'(valid_out), 64'd0);
    check_output("flush_skid_ready", 64'(ready_out), 64'd1);

    $display("[TB] counter saturation");
    ready_in = 1'b1;
    apply_stimulus(7);
    repeat (300) tick();
    valid_in = 1'b0;
    drain();
    check_output("cnt_sat_model", 64'(illegal_cnt_out), 64'(model_cnt));
    check_output("cnt_sat_255", 64'(illegal_cnt_out), 64'd255);

    $display("[TB] reset while stalled");
    ready_in = 1'b0;
    apply_stimulus(4);
    tick();
    apply_stimulus(5);
    tick();
    valid_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check_output("rst_stall_valid", 64'(valid_out), 64'd0);
    check_output("rst_stall_bundle", 64'(act_bundle()), 64'd0);
    check_output("rst_stall_cnt", 64'(illegal_cnt_out), 64'd0);
    check_output("rst_stall_ready", 64'(ready_out), 64'd1);
    ready_in = 1'b1;
    tick();
    tick();
    check_output("final_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
